lift_scheduler: RTL

Request scheduler and motion sequencer for the 4-floor lift. Latches floor-call requests and serves them in SCAN order (continue in current direction while calls remain ahead, then reverse). Times floor-to-floor travel and door dwell, and publishes the car position as a 2-bit floor code, which drives the floor-state FSM's floor input. One instance per car.

---
 rtl/lift_pkg.sv | 19 +
 rtl/lift_timer.sv | 19 +
 rtl/lift_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// lift_pkg: shared types, widths and SCAN search helpers for the lift scheduler
package lift_pkg;
    localparam int FLOOR_W = 2;
    localparam int NF = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;
    typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;
    function automatic logic any_above(input logic [NF-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NF; i++) r = r | (p[i] & (i > int'(f)));
        return r;
    endfunction
    function automatic logic any_below(input logic [NF-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NF; i++) r = r | (p[i] & (i < int'(f)));
        return r;
    endfunction
endpackage

// File: rtl/lift_timer.sv
// lift_timer: loadable down-counter; done marks the final enabled cycle of a loaded span
module lift_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_done = i_en && r_cnt == W'(1);
endmodule

// File: rtl/lift_scheduler.sv
// lift_scheduler: latches floor calls and serves them in SCAN order with timed travel and door dwell
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int NFLOORS    = 4,
    parameter int TRAVEL_CYC = 8,
    parameter int DOOR_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] req,
    output logic [FLOOR_W-1:0] floor,
    output logic               moving_up,
    output logic               moving_dn,
    output logic               door_open,
    output logic [NFLOORS-1:0] pending,
    output logic               arrive
);
    localparam int TW = $clog2(TRAVEL_CYC + 1);
    localparam int DW = $clog2(DOOR_CYC + 1);
    state_t               r_state, w_nxt_state;
    dir_t                 r_dir, w_nxt_dir;
    logic [FLOOR_W-1:0]   r_floor, w_nxt_floor, w_step;
    logic [NFLOORS-1:0]   r_pending, w_clr, w_req_m;
    logic                 r_arrive, w_arrive;
    logic                 w_trav_load, w_trav_done, w_door_load, w_door_done;
    logic                 w_ahead, w_behind, w_further;
    lift_timer #(.W(TW)) u_travel (
        .clk(clk), .rst(rst), .i_load(w_trav_load), .i_en(r_state == MOVE),
        .i_val(TW'(TRAVEL_CYC)), .o_done(w_trav_done)
    );
    lift_timer #(.W(DW)) u_door (
        .clk(clk), .rst(rst), .i_load(w_door_load), .i_en(r_state == DOOR),
        .i_val(DW'(DOOR_CYC)), .o_done(w_door_done)
    );
    assign w_step    = r_dir == UP ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
    assign w_ahead   = r_dir == UP ? any_above(r_pending, r_floor) : any_below(r_pending, r_floor);
    assign w_behind  = r_dir == UP ? any_below(r_pending, r_floor) : any_above(r_pending, r_floor);
    assign w_further = r_dir == UP ? any_above(r_pending, w_step) : any_below(r_pending, w_step);
    // a call for the floor whose door is open extends the dwell instead of latching
    assign w_req_m   = r_state == DOOR ? req & ~(NFLOORS'(1) << r_floor) : req;
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dir   = r_dir;
        w_nxt_floor = r_floor;
        w_clr       = '0;
        w_trav_load = 1'b0;
        w_door_load = 1'b0;
        w_arrive    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending[r_floor]) begin
                    w_nxt_state     = DOOR;
                    w_clr[r_floor]  = 1'b1;
                    w_door_load     = 1'b1;
                end else if (w_ahead || w_behind) begin
                    w_nxt_state = MOVE;
                    w_nxt_dir   = w_ahead ? r_dir : (r_dir == UP ? DOWN : UP);
                    w_trav_load = 1'b1;
                end
            end
            MOVE: begin
                if (w_trav_done) begin
                    w_nxt_floor = w_step;
                    w_arrive    = 1'b1;
                    if (r_pending[w_step]) begin
                        w_nxt_state    = DOOR;
                        w_clr[w_step]  = 1'b1;
                        w_door_load    = 1'b1;
                    end else if (w_further) begin
                        w_trav_load = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            DOOR: begin
                w_door_load = req[r_floor];
                w_nxt_state = (w_door_done && !req[r_floor]) ? IDLE : DOOR;
            end
            default: w_nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dir     <= UP;
            r_floor   <= '0;
            r_pending <= '0;
            r_arrive  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_dir     <= w_nxt_dir;
            r_floor   <= w_nxt_floor;
            r_pending <= (r_pending | w_req_m) & ~w_clr;
            r_arrive  <= w_arrive;
        end
    end
    assign floor     = r_floor;
    assign pending   = r_pending;
    assign arrive    = r_arrive;
    assign door_open = r_state == DOOR;
    assign moving_up = r_state == MOVE && r_dir == UP;
    assign moving_dn = r_state == MOVE && r_dir == DOWN;
endmodule
